// File: rtl/mmm_control.sv
// Sequencer for a matrix-multiply MAC pipeline: walks m/n/k, issues operand reads,
// throttles element starts against output FIFO space and emits write/finish strobes.
module mmm_control #(
  parameter int M       = 7,
  parameter int N       = 9,
  parameter int MAXK    = 8,
  parameter int MAC_LAT = 2,
  localparam int K_BITS = $clog2(MAXK + 1),
  localparam int AW     = $clog2(M * MAXK),
  localparam int BW     = $clog2(MAXK * N),
  localparam int CW     = $clog2(N + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_matrices_loaded,
  input  logic [K_BITS-1:0] i_k,
  output logic [AW-1:0]     o_a_read_addr,
  output logic [BW-1:0]     o_b_read_addr,
  output logic              o_valid_input,
  output logic              o_clear_acc,
  input  logic [CW-1:0]     i_capacity,
  output logic              o_wr_en,
  output logic              o_compute_finished
);

  localparam int MW = $clog2(M + 1);
  localparam int NW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_STALL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [K_BITS-1:0]   r_klat;
  logic [K_BITS-1:0]   r_k;
  logic [MW-1:0]       r_m;
  logic [NW-1:0]       r_n;
  logic [CW-1:0]       r_inflight;
  logic                r_seen_low;
  logic                r_valid;
  logic                r_clear;
  logic [MAC_LAT+1:0]  r_last_pipe;

  logic w_issue;
  logic w_load;
  logic w_k_last;
  logic w_n_last;
  logic w_m_last;
  logic w_can_start;
  logic w_elem_start;

  assign w_k_last     = (r_k == (r_klat - K_BITS'(1)));
  assign w_n_last     = (r_n == NW'(N - 1));
  assign w_m_last     = (r_m == MW'(M - 1));
  assign w_can_start  = (i_capacity > r_inflight);
  assign w_load       = (r_state == S_IDLE) && i_matrices_loaded && r_seen_low;
  assign w_elem_start = w_issue && (r_k == '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_next = (i_k == '0) ? S_DONE : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        // Only the k=0 issue of an element needs FIFO room; the rest of it streams freely.
        if ((r_k == '0) && !w_can_start) begin
          w_state_next = S_STALL;
        end else begin
          w_issue = 1'b1;
          if (w_k_last && w_n_last && w_m_last) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_STALL: begin
        if (w_can_start) begin
          w_state_next = S_COMPUTE;
        end
      end
      S_DRAIN: begin
        if (r_inflight == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_klat <= '0;
      r_k    <= '0;
      r_n    <= '0;
      r_m    <= '0;
    end else if (w_load) begin
      r_klat <= i_k;
      r_k    <= '0;
      r_n    <= '0;
      r_m    <= '0;
    end else if (w_issue) begin
      if (w_k_last) begin
        r_k <= '0;
        if (w_n_last) begin
          r_n <= '0;
          r_m <= r_m + MW'(1);
        end else begin
          r_n <= r_n + NW'(1);
        end
      end else begin
        r_k <= r_k + K_BITS'(1);
      end
    end
  end

  // A fresh run requires matrices_loaded to be seen low first, including after reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_seen_low <= 1'b0;
    end else if (!i_matrices_loaded) begin
      r_seen_low <= 1'b1;
    end else if (w_load) begin
      r_seen_low <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_inflight <= '0;
    end else begin
      case ({w_elem_start, o_wr_en})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Bit j of the pipe is high 1+j cycles after a last-k issue; the top bit drives the write.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid     <= 1'b0;
      r_clear     <= 1'b0;
      r_last_pipe <= '0;
    end else begin
      r_valid     <= w_issue;
      r_clear     <= w_elem_start;
      r_last_pipe <= {r_last_pipe[MAC_LAT:0], w_issue && w_k_last};
    end
  end

  assign o_a_read_addr      = w_issue ? (AW'(r_m) * AW'(r_klat) + AW'(r_k)) : '0;
  assign o_b_read_addr      = w_issue ? (BW'(r_k) * BW'(N) + BW'(r_n)) : '0;
  assign o_valid_input      = r_valid;
  assign o_clear_acc        = r_clear;
  assign o_wr_en            = r_last_pipe[MAC_LAT+1];
  assign o_compute_finished = (r_state == S_DONE);

endmodule

// File: tb/tb_mmm_control.sv
// Bench for mmm_control: memories and MAC pipe are modelled behaviourally and every
// written result is compared against a directly computed matrix product.
module tb_mmm_control;
  localparam int M       = 7;
  localparam int N       = 9;
  localparam int MAXK    = 8;
  localparam int MAC_LAT = 2;
  localparam int K_BITS  = $clog2(MAXK + 1);
  localparam int AW      = $clog2(M * MAXK);
  localparam int BW      = $clog2(MAXK * N);
  localparam int CW      = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ml = 1'b0;
  logic [K_BITS-1:0] k_in = '0;
  logic [CW-1:0]     cap = '0;
  logic [AW-1:0]     a_addr;
  logic [BW-1:0]     b_addr;
  logic              valid_in;
  logic              clear_acc;
  logic              wr_en;
  logic              finished;

  mmm_control #(.M(M), .N(N), .MAXK(MAXK), .MAC_LAT(MAC_LAT)) dut (
    .i_clk             (clk),
    .i_reset           (rst_n),
    .i_matrices_loaded (ml),
    .i_k               (k_in),
    .o_a_read_addr     (a_addr),
    .o_b_read_addr     (b_addr),
    .o_valid_input     (valid_in),
    .o_clear_acc       (clear_acc),
    .i_capacity        (cap),
    .o_wr_en           (wr_en),
    .o_compute_finished(finished)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int mem_a [M*MAXK];
  int mem_b [MAXK*N];
  int cref  [M*N];

  bit mon_en = 1'b0;
  int cyc = 0;
  int run_k = 1;
  int exp_idx, acc;
  int n_valid, n_clear, n_start, n_wr, n_cf;
  int first_valid, last_valid, first_wr;
  int hist [16];
  int wr_q [$];
  logic [AW-1:0] a_q = '0;
  logic [BW-1:0] b_q = '0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Environment: 1-cycle read memories feeding an accumulator whose output lags MAC_LAT cycles.
  always @(negedge clk) begin : monitor
    int kk, nn, mm, rk, got, exp_res;
    bit exp_wr;
    cyc++;
    if (mon_en) begin
      rk = (run_k > 0) ? run_k : 1;
      if (valid_in) begin
        kk = exp_idx % rk;
        nn = (exp_idx / rk) % N;
        mm = exp_idx / (rk * N);
        check("a_addr", int'(a_q), mm * rk + kk);
        check("b_addr", int'(b_q), kk * N + nn);
        check("clear_acc", int'(clear_acc), (kk == 0) ? 1 : 0);
        acc = ((kk == 0) ? 0 : acc) + mem_a[int'(a_q)] * mem_b[int'(b_q)];
        if (kk == rk - 1) wr_q.push_back(cyc + MAC_LAT + 1);
        if (kk == 0) n_start++;
        if (clear_acc) n_clear++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
        n_valid++;
        exp_idx++;
      end else begin
        check("clear_without_valid", int'(clear_acc), 0);
      end
      hist[cyc % 16] = acc;
      exp_wr = (wr_q.size() > 0) && (wr_q[0] == cyc);
      check("wr_en_timing", int'(wr_en), exp_wr ? 1 : 0);
      if (exp_wr) void'(wr_q.pop_front());
      if (wr_en) begin
        exp_res = (n_wr < M * N) ? cref[n_wr] : -1;
        got = hist[(cyc - MAC_LAT - 1) % 16];
        $display("write %0d C[%0d][%0d] = %0d ref %0d at cycle %0d",
                 n_wr, n_wr / N, n_wr % N, got, exp_res, cyc);
        check("result", got, exp_res);
        if (first_wr < 0) first_wr = cyc;
        n_wr++;
      end
      if (finished) n_cf++;
    end
    a_q = a_addr;
    b_q = b_addr;
  end

  task automatic load_mats(input int kk);
    for (int i = 0; i < M * MAXK; i++) mem_a[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < MAXK * N; i++) mem_b[i] = int'($urandom_range(0, 255));
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        int s;
        s = 0;
        for (int k = 0; k < kk; k++) s += mem_a[m * kk + k] * mem_b[k * N + n];
        cref[m * N + n] = s;
      end
    end
  endtask

  task automatic start_run(input int kk);
    load_mats(kk);
    exp_idx = 0; acc = 0;
    n_valid = 0; n_clear = 0; n_start = 0; n_wr = 0; n_cf = 0;
    first_valid = -1; last_valid = -1; first_wr = -1;
    wr_q.delete();
    run_k = kk;
    mon_en = 1'b1;
    k_in = K_BITS'(kk);
    ml = 1'b1;
  endtask

  task automatic wait_done(input bit rand_cap);
    for (int t = 0; t < 4000 && n_cf == 0; t++) begin
      tick();
      if (rand_cap) cap = CW'($urandom_range(0, 9));
    end
    check("run_completed", n_cf, 1);
    cap = CW'(9);
    repeat (3) tick();
  endtask

  task automatic end_checks(input int kk);
    check("valid_count", n_valid, M * N * kk);
    check("clear_count", n_clear, M * N);
    check("write_count", n_wr, M * N);
    check("finish_pulses", n_cf, 1);
    ml = 1'b0;
    repeat (3) tick();
    mon_en = 1'b0;
  endtask

  initial begin
    int kk, seen_wr, seen_cf, seen_valid;
    #1;
    check("rst_a_addr", int'(a_addr), 0);
    check("rst_b_addr", int'(b_addr), 0);
    check("rst_valid", int'(valid_in), 0);
    check("rst_clear", int'(clear_acc), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_finished", int'(finished), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cap = CW'(9);
    repeat (2) tick();

    // Full K, ample capacity: uninterrupted issue stream.
    start_run(8);
    wait_done(1'b0);
    check("k8_issue_span", last_valid - first_valid, M * N * 8 - 1);
    end_checks(8);

    // K=1: every issue starts and finishes an element.
    start_run(1);
    wait_done(1'b0);
    check("k1_issue_span", last_valid - first_valid, M * N - 1);
    check("k1_first_write_delay", first_wr - first_valid, MAC_LAT + 1);
    end_checks(1);

    // K=0: immediate finish, no traffic.
    start_run(0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("k0_finished", n_cf, 1);
    check("k0_valid", n_valid, 0);
    check("k0_writes", n_wr, 0);
    ml = 1'b0;
    repeat (3) tick();
    mon_en = 1'b0;

    // Capacity pulled to 0 after three starts, then released to exactly 1.
    start_run(4);
    for (int t = 0; t < 200 && n_start < 3; t++) tick();
    cap = '0;
    repeat (40) tick();
    check("blocked_starts", n_start, 3);
    check("blocked_writes", n_wr, 3);
    cap = CW'(1);
    for (int t = 0; t < 4000 && n_cf == 0; t++) tick();
    check("cap1_completed", n_cf, 1);
    cap = CW'(9);
    repeat (3) tick();
    end_checks(4);

    // Reset in the middle of element 20 aborts everything.
    kk = int'($urandom_range(2, 8));
    start_run(kk);
    for (int t = 0; t < 400 && n_start < 20; t++) tick();
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_a_addr", int'(a_addr), 0);
    check("abort_b_addr", int'(b_addr), 0);
    check("abort_valid", int'(valid_in), 0);
    check("abort_clear", int'(clear_acc), 0);
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_finished", int'(finished), 0);
    ml = 1'b0;
    seen_wr = 0; seen_cf = 0;
    for (int t = 0; t < 8; t++) begin
      if (t == 4) rst_n = 1'b1;
      tick();
      seen_wr += int'(wr_en);
      seen_cf += int'(finished);
    end
    check("abort_no_writes", seen_wr, 0);
    check("abort_no_finish", seen_cf, 0);
    start_run(int'($urandom_range(1, 8)));
    wait_done(1'b0);
    end_checks(run_k);

    // Load held high after finish: no second run.
    kk = int'($urandom_range(2, 8));
    start_run(kk);
    wait_done(1'b0);
    seen_valid = n_valid;
    repeat (30) tick();
    check("held_no_rerun", n_valid - seen_valid, 0);
    end_checks(kk);

    // Random K with capacity wandering every cycle.
    for (int r = 0; r < 2; r++) begin
      kk = int'($urandom_range(1, 8));
      start_run(kk);
      wait_done(1'b1);
      end_checks(kk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
